// File: rtl/conv_window_scheduler.sv
// Drives one shared MAC PE over every KxK window of an IN_DIM x IN_DIM tile,
// then holds each window result on a valid/ready port until it is accepted.
module conv_window_scheduler #(
  parameter int IN_DIM = 4,
  parameter int K = 3,
  parameter int LAT = 2,
  localparam int OUT_DIM = IN_DIM - K + 1,
  localparam int IW = $clog2(IN_DIM),
  localparam int KW = $clog2(K),
  localparam int OW = ($clog2(OUT_DIM) > 1) ? $clog2(OUT_DIM) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pe_rst,
  output logic          op_valid,
  output logic [IW-1:0] in_row,
  output logic [IW-1:0] in_col,
  output logic [KW-1:0] f_row,
  output logic [KW-1:0] f_col,
  input  logic [7:0]    pe_out,
  output logic [7:0]    res_data,
  output logic [OW-1:0] res_row,
  output logic [OW-1:0] res_col,
  output logic          res_valid,
  input  logic          res_ready
);

  localparam int DW = ($clog2(LAT) > 1) ? $clog2(LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUT, S_DONE} state_t;

  state_t        state, state_n;
  logic [OW-1:0] wr, wc;
  logic [KW-1:0] tr, tc;
  logic [DW-1:0] dc;
  logic [IW-1:0] in_row_q, in_col_q;
  logic [KW-1:0] f_row_q, f_col_q;
  logic          tap_last, drain_last, win_last, wc_last;

  assign tap_last   = (tr == KW'(K - 1)) && (tc == KW'(K - 1));
  assign drain_last = (dc == DW'(LAT - 1));
  assign wc_last    = (wc == OW'(OUT_DIM - 1));
  assign win_last   = (wr == OW'(OUT_DIM - 1)) && wc_last;

  always_comb begin
    state_n  = state;
    busy     = 1'b1;
    done     = 1'b0;
    pe_rst   = 1'b0;
    op_valid = 1'b0;
    case (state)
      S_IDLE: begin
        busy   = 1'b0;
        pe_rst = 1'b1;
        if (start) state_n = S_CLEAR;
      end
      S_CLEAR: begin
        pe_rst  = 1'b1;
        state_n = S_FEED;
      end
      S_FEED: begin
        op_valid = 1'b1;
        if (tap_last) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_last) state_n = S_OUT;
      end
      S_OUT: begin
        if (res_ready) state_n = win_last ? S_DONE : S_CLEAR;
      end
      S_DONE: begin
        done    = 1'b1;
        pe_rst  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Filter taps are walked in reverse to give the 180-degree rotation the PE wiring expects.
  always_comb begin
    in_row = in_row_q;
    in_col = in_col_q;
    f_row  = f_row_q;
    f_col  = f_col_q;
    if (op_valid) begin
      in_row = IW'(wr) + IW'(tr);
      in_col = IW'(wc) + IW'(tc);
      f_row  = KW'(K - 1) - tr;
      f_col  = KW'(K - 1) - tc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr        <= '0;
      wc        <= '0;
      tr        <= '0;
      tc        <= '0;
      dc        <= '0;
      in_row_q  <= '0;
      in_col_q  <= '0;
      f_row_q   <= '0;
      f_col_q   <= '0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
      res_valid <= 1'b0;
    end else begin
      state    <= state_n;
      in_row_q <= in_row;
      in_col_q <= in_col;
      f_row_q  <= f_row;
      f_col_q  <= f_col;
      case (state)
        S_IDLE: begin
          if (start) begin
            wr <= '0;
            wc <= '0;
          end
        end
        S_CLEAR: begin
          tr <= '0;
          tc <= '0;
        end
        S_FEED: begin
          dc <= '0;
          if (tc == KW'(K - 1)) begin
            tc <= '0;
            if (!tap_last) tr <= tr + KW'(1);
          end else begin
            tc <= tc + KW'(1);
          end
        end
        S_DRAIN: begin
          dc <= dc + DW'(1);
          if (drain_last) begin
            res_data  <= pe_out;
            res_row   <= wr;
            res_col   <= wc;
            res_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!win_last) begin
              if (wc_last) begin
                wc <= '0;
                wr <= wr + OW'(1);
              end else begin
                wc <= wc + OW'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: MAC PE model, result scoreboard, operand-order
// and control corner checks with the default 4x4 tile / 3x3 filter / LAT=2.
module tb_conv_window_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, res_ready;
  logic       busy, done, pe_rst, op_valid, res_valid;
  logic [1:0] in_row, in_col, f_row, f_col;
  logic [7:0] pe_out, res_data;
  logic [0:0] res_row, res_col;

  conv_window_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pe_rst(pe_rst), .op_valid(op_valid),
    .in_row(in_row), .in_col(in_col), .f_row(f_row), .f_col(f_col),
    .pe_out(pe_out), .res_data(res_data), .res_row(res_row), .res_col(res_col),
    .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dat;
    int         row;
    int         col;
    int         cyc;
  } exp_t;

  localparam logic [31:0] RST_VEC = 32'h0008_0000;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] op_log[$];
  logic [7:0] in_mem [0:3][0:3];
  logic [7:0] flt    [0:3][0:3];
  logic [7:0] acc, pe_d;
  int         n_tests = 0, n_fail = 0;
  int         cyc = 0, t0 = 0, exp_done = 0, rise_r = 0, blen = 0;
  bit         done_seen, pv, pacc, pov, ppr;
  logic [7:0] hold_dat;
  logic [7:0] v_one [4] = '{8'd54, 8'd63, 8'd90, 8'd99};
  logic [7:0] v_ovf [4] = '{8'd162, 8'd189, 8'd14, 8'd41};
  logic [7:0] exp_ops [9] = '{8'b01_01_10_10, 8'b01_10_10_01, 8'b01_11_10_00,
                              8'b10_01_01_10, 8'b10_10_01_01, 8'b10_11_01_00,
                              8'b11_01_00_10, 8'b11_10_00_01, 8'b11_11_00_00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({busy, done, op_valid, pe_rst, res_valid, res_data, res_row, res_col,
                in_row, in_col, f_row, f_col});
  endfunction

  // PE: accumulator plus one output stage gives LAT=2.
  always @(posedge clk) begin
    if (pe_rst) acc <= 8'd0;
    else if (op_valid) acc <= acc + 8'(in_mem[in_row][in_col] * flt[f_row][f_col]);
    pe_d <= acc;
  end
  assign pe_out = pe_d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int r;
    r = cyc - t0;
    if (rst) begin
      pv = 0; pacc = 0; pov = 0; ppr = 1;
    end else begin
      if (done) begin
        chk("done_cyc", r, exp_done);
        done_seen = 1;
      end
      if (res_valid && !pv) begin
        rise_r = r;
        chk("res_expected", 32'(sb.size() > 0), 1);
      end
      if (res_valid && pv && !pacc) begin
        chk("hold_dat", res_data, hold_dat);
        chk("stall_op", op_valid, 0);
      end
      if (res_valid && res_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("res_dat", res_data, e.dat);
        chk("res_row", res_row, e.row);
        chk("res_col", res_col, e.col);
        chk("res_cyc", rise_r, e.cyc);
      end
      if (op_valid && !pov) begin
        chk("pe_rst_pre", ppr, 1);
        blen = 0;
      end
      if (op_valid) begin
        blen++;
        op_log.push_back({in_row, in_col, f_row, f_col});
        chk("pe_rst_feed", pe_rst, 0);
      end
      if (!op_valid && pov) chk("burst_len", blen, 9);
      pv = res_valid; pacc = res_valid && res_ready; hold_dat = res_data;
      pov = op_valid; ppr = pe_rst;
    end
  end

  task automatic push_pass(input logic [7:0] v [4], input int stall);
    exp_t x;
    for (int k = 0; k < 4; k++) begin
      x.dat = v[k];
      x.row = k / 2;
      x.col = k % 2;
      x.cyc = 13 + 13 * k + ((k > 0) ? stall : 0);
      sb.push_back(x);
    end
    exp_done = 53 + stall;
  endtask

  task automatic set_filter(input logic [7:0] val);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) flt[i][j] = val;
  endtask

  task automatic run_pass(input int stall, input bit glitch);
    int r;
    @(posedge clk); #1;
    t0 = cyc;
    done_seen = 0;
    start = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      r = cyc - t0;
      start = glitch && (r == 5);
      res_ready = !(r >= 13 && r < 13 + stall);
      if (done_seen) break;
    end
    start = 1'b0;
    res_ready = 1'b1;
    chk("done_seen", 32'(done_seen), 1);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) in_mem[i][j] = 8'(4 * i + j + 1);
    set_filter(8'd1);
    rst = 1'b1; start = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("reset_vec", out_vec(), RST_VEC);
    end

    // Full pass, then operand order of window (1,1).
    op_log.delete();
    push_pass(v_one, 0);
    run_pass(0, 0);
    chk("op_count", op_log.size(), 36);
    for (int i = 0; i < 9; i++)
      if (op_log.size() == 36) chk("op_order", op_log[27 + i], exp_ops[i]);

    // Five stalled cycles on window 0.
    push_pass(v_one, 5);
    run_pass(5, 0);

    set_filter(8'd3);
    push_pass(v_ovf, 0);
    run_pass(0, 0);

    // Start pulsed during FEED must not queue a second pass.
    set_filter(8'd1);
    push_pass(v_one, 0);
    run_pass(0, 1);
    repeat (3) @(negedge clk);
    chk("no_second_pass", busy, 0);

    // Reset in cycle 6 of a pass.
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("rst_cycle", cyc - t0, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vec", out_vec(), RST_VEC);
    sb.delete();
    op_log.delete();
    push_pass(v_one, 0);
    run_pass(0, 0);
    chk("first_op", (op_log.size() > 0) ? 32'(op_log[0]) : 32'hFFFF, 32'b00_00_10_10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Sequences one shared 8-bit multiply-accumulate PE over every valid KxK window of an IN_DIM x IN_DIM input tile. The scheduler owns the PE's clear signal and emits the input and filter operand coordinates each cycle. It waits for the PE pipeline to drain, then presents each window result on a valid/ready output port. It sits between the tile/filter register banks, which it addresses, and the downstream result buffer.

## Interface
- IN_DIM, default 4: input tile edge length. Must be at least K.
- K, default 3: filter edge length.
- LAT, default 2: cycles from the last operand cycle until pe_out holds the final sum. Must be at least 1.
- Derived, not overridable:
  - OUT_DIM = IN_DIM-K+1.
  - IW = clog2(IN_DIM).
  - KW = clog2(K).
  - OW = max(1, clog2(OUT_DIM)).

Ports:
- clk  in  1  clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a full tile pass. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the cycle DONE is left.
- done  out  1  one-cycle pulse after the last result is accepted.
- pe_rst  out  1  PE accumulator clear.
- op_valid  out  1  operand coordinates are valid this cycle.
- in_row, in_col  out  IW  input tile coordinate.
- f_row, f_col  out  KW  filter coordinate.
- pe_out  in  8  PE accumulator output.
- res_data  out  8  captured window result.
- res_row, res_col  out  OW  output coordinate of res_data.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.

## Operation
- States are IDLE, CLEAR, FEED, DRAIN, OUT and DONE.
- The window counter (wr, wc) covers 0..OUT_DIM-1 in row-major order.
- The tap counter (tr, tc) covers 0..K-1 in row-major order.
- IDLE:
  - pe_rst=1, busy=0.
  - start=1 → window (0,0), go to CLEAR.
- CLEAR:
  - pe_rst=1 for exactly 1 cycle.
  - Tap counter is set to (0,0).
  - Go to FEED.
- FEED:
  - pe_rst=0, op_valid=1 for K*K consecutive cycles.
  - in_row=wr+tr, in_col=wc+tc.
  - f_row=K-1-tr, f_col=K-1-tc. This is the 180° kernel rotation expected by the PE filter wiring.
  - After tap (K-1,K-1) → DRAIN.
- DRAIN:
  - op_valid=0 for LAT cycles.
  - On the clock edge ending the last DRAIN cycle, res_data←pe_out, res_row←wr, res_col←wc, res_valid←1.
  - Go to OUT.
- OUT:
  - res_valid, res_data, res_row and res_col hold stable until res_valid&&res_ready.
  - On acceptance, res_valid←0.
  - If this was the last window (OUT_DIM-1, OUT_DIM-1) → DONE.
  - Otherwise advance the window: wc++; when wc wraps to 0, wr++. Then go to CLEAR.
- DONE:
  - done=1 for 1 cycle, pe_rst=1.
  - Go to IDLE.
- Arithmetic: no data arithmetic is performed. pe_out is captured bit-exact, so overflow wrap is the PE's behaviour.
- Coordinate outputs: when op_valid=0 they hold their last value. They are 0 after reset.
- start while busy=1 is ignored; it is not queued.
- res_ready while res_valid=0 is ignored.
- Operands are valid only in FEED; no sequencing occurs outside the states above.

## Timing
- Reset values:
  - busy=0, done=0, op_valid=0, pe_rst=1, res_valid=0.
  - res_data=0, res_row=0, res_col=0.
  - All coordinates 0; state IDLE.
- rst=1 in any state, including mid-FEED or mid-OUT, gives reset values on the next cycle and discards the pass.
- Start latency: start is sampled at edge t. Then CLEAR runs in cycle t+1 and the first op_valid is in cycle t+2.
- Per-window cost is 1 + K*K + LAT + (OUT cycles, at least 1). With defaults and res_ready=1 this is 13 cycles.
- With defaults, res_ready=1 and start at cycle 0:
  - Window k is in OUT at cycle 13+13k.
  - done pulses at cycle 53.
  - busy is high in cycles 1-53.
- Each cycle of res_ready=0 in OUT stalls the schedule by exactly 1 cycle. op_valid stays 0 during the stall.

## Test plan
- Reset state:
  - Apply rst for 2 cycles, then release with start=0.
  - All outputs must be at their reset values and remain so for 10 cycles.
- Full pass with default parameters:
  - Bench MAC model with LAT=2; in[i][j]=4i+j+1; filter all 1; res_ready=1.
  - Results must be 54, 63, 90, 99 at res (row,col) = (0,0), (0,1), (1,0), (1,1), with res_valid in cycles 13, 26, 39, 52.
  - done must pulse in cycle 53.
- Operand order in window (1,1):
  - in coordinates must be (1,1),(1,2),(1,3),(2,1),(2,2),(2,3),(3,1),(3,2),(3,3).
  - f coordinates must be (2,2),(2,1),(2,0),(1,2),(1,1),(1,0),(0,2),(0,1),(0,0).
  - pe_rst must be high exactly 1 cycle before each 9-cycle op_valid burst.
- Backpressure:
  - Hold res_ready=0 for 5 cycles while window 0 is in OUT.
  - res_valid=1 and res_data=54 must stay stable, with op_valid=0.
  - Window 1 CLEAR must follow acceptance, and done must pulse at cycle 58.
- Overflow pass-through:
  - Filter all 3.
  - Results must be 162, 189, 14, 41 (8-bit wrap).
- Control corner cases:
  - Pulse start during FEED: no effect, single pass.
  - Assert rst in cycle 6: reset values in cycle 7.
  - Issue a new start: first operands must be window (0,0), tap (0,0).
